// File: rtl/hazard_unit_if.sv
// Pipeline hazard bundle: register tags and enables in from the pipeline, stall/forward controls out.
// The master side is the hazard unit; the slave side is the pipeline that consumes the controls.
interface hazard_unit_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] write_reg_e;
    logic [4:0] write_reg_m;
    logic [4:0] write_reg_w;
    logic       reg_write_e;
    logic       reg_write_m;
    logic       reg_write_w;
    logic       mem_to_reg_e;
    logic       mem_to_reg_m;
    logic       branch_d;
    logic       hilo_read_d;
    logic       md_start_e;
    logic       md_is_div_e;

    logic       stall_f;
    logic       stall_d;
    logic       flush_e;
    logic       forward_a_d;
    logic       forward_b_d;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       md_busy;

    modport master (
        input  rs_d, rt_d, rs_e, rt_e,
        input  write_reg_e, write_reg_m, write_reg_w,
        input  reg_write_e, reg_write_m, reg_write_w,
        input  mem_to_reg_e, mem_to_reg_m,
        input  branch_d, hilo_read_d, md_start_e, md_is_div_e,
        output stall_f, stall_d, flush_e,
        output forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        output md_busy
    );

    modport slave (
        output rs_d, rt_d, rs_e, rt_e,
        output write_reg_e, write_reg_m, write_reg_w,
        output reg_write_e, reg_write_m, reg_write_w,
        output mem_to_reg_e, mem_to_reg_m,
        output branch_d, hilo_read_d, md_start_e, md_is_div_e,
        input  stall_f, stall_d, flush_e,
        input  forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        input  md_busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / branch stalls, forwarding selects and mult/div busy tracking.
// Optional HAZARD_STALL_COUNT_EN adds a free-running 32-bit count of stalled cycles.
module hazard_unit #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_unit_if.master hz
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0]   stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_e  state_q;
    logic [3:0] cnt_q;
    logic [3:0] load_val;

    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic stall_any;

    // $0 is hard-wired, so a zero tag never creates a dependency.
    function automatic logic tag_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_comb begin
        hz.forward_a_e = 2'b00;
        if (hz.reg_write_m && tag_hit(hz.write_reg_m, hz.rs_e)) begin
            hz.forward_a_e = 2'b10;
        end else if (hz.reg_write_w && tag_hit(hz.write_reg_w, hz.rs_e)) begin
            hz.forward_a_e = 2'b01;
        end

        hz.forward_b_e = 2'b00;
        if (hz.reg_write_m && tag_hit(hz.write_reg_m, hz.rt_e)) begin
            hz.forward_b_e = 2'b10;
        end else if (hz.reg_write_w && tag_hit(hz.write_reg_w, hz.rt_e)) begin
            hz.forward_b_e = 2'b01;
        end

        hz.forward_a_d = hz.reg_write_m && tag_hit(hz.write_reg_m, hz.rs_d);
        hz.forward_b_d = hz.reg_write_m && tag_hit(hz.write_reg_m, hz.rt_d);
    end

    always_comb begin
        lw_stall = hz.mem_to_reg_e &&
                   (tag_hit(hz.write_reg_e, hz.rs_d) || tag_hit(hz.write_reg_e, hz.rt_d));

        br_stall = hz.branch_d &&
                   ((hz.reg_write_e &&
                     (tag_hit(hz.write_reg_e, hz.rs_d) || tag_hit(hz.write_reg_e, hz.rt_d))) ||
                    (hz.mem_to_reg_m &&
                     (tag_hit(hz.write_reg_m, hz.rs_d) || tag_hit(hz.write_reg_m, hz.rt_d))));

        md_stall  = (state_q == BUSY) && hz.hilo_read_d;
        stall_any = lw_stall | br_stall | md_stall;

        hz.stall_f = stall_any;
        hz.stall_d = stall_any;
        hz.flush_e = stall_any;
        hz.md_busy = (state_q == BUSY);
    end

    assign load_val = hz.md_is_div_e ? DIV_LOAD : MULT_LOAD;

    // DONE accepts a new issue exactly like IDLE so back-to-back ops lose no cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (hz.md_start_e) begin
                        cnt_q   <= load_val;
                        state_q <= (load_val == '0) ? DONE : BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (stall_any) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, multi-cycle mult/div sequences,
// and randomized traffic against a cycle-count reference model.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_unit_if hif ();

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    hazard_unit #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (12)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hif)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wre, wrm, wrw;
        logic       rwe, rwm, rww, mte, mtm, br, hilo;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[12];

    int          busy_left;
    logic [31:0] cnt_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e[1:0], fwd_b_e[1:0], md_busy}
    function automatic logic [9:0] outs();
        return {hif.stall_f, hif.stall_d, hif.flush_e, hif.forward_a_d, hif.forward_b_d,
                hif.forward_a_e, hif.forward_b_e, hif.md_busy};
    endfunction

    function automatic logic m(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [9:0] ref_outs(input logic busy);
        logic [1:0] fae, fbe;
        logic lw, br, st;
        fae = (hif.reg_write_m && m(hif.write_reg_m, hif.rs_e)) ? 2'd2 :
              (hif.reg_write_w && m(hif.write_reg_w, hif.rs_e)) ? 2'd1 : 2'd0;
        fbe = (hif.reg_write_m && m(hif.write_reg_m, hif.rt_e)) ? 2'd2 :
              (hif.reg_write_w && m(hif.write_reg_w, hif.rt_e)) ? 2'd1 : 2'd0;
        lw  = hif.mem_to_reg_e && (m(hif.write_reg_e, hif.rs_d) || m(hif.write_reg_e, hif.rt_d));
        br  = hif.branch_d &&
              ((hif.reg_write_e && (m(hif.write_reg_e, hif.rs_d) || m(hif.write_reg_e, hif.rt_d))) ||
               (hif.mem_to_reg_m && (m(hif.write_reg_m, hif.rs_d) || m(hif.write_reg_m, hif.rt_d))));
        st  = lw | br | (busy & hif.hilo_read_d);
        return {st, st, st, hif.reg_write_m && m(hif.write_reg_m, hif.rs_d),
                hif.reg_write_m && m(hif.write_reg_m, hif.rt_d), fae, fbe, busy};
    endfunction

    function automatic vec_t mk(input logic [4:0] rs_d, rt_d, rs_e, rt_e, wre, wrm, wrw,
                                input logic rwe, rwm, rww, mte, mtm, br, hilo,
                                input logic [9:0] exp);
        vec_t v;
        v.rs_d = rs_d; v.rt_d = rt_d; v.rs_e = rs_e; v.rt_e = rt_e;
        v.wre = wre; v.wrm = wrm; v.wrw = wrw;
        v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.mte = mte; v.mtm = mtm;
        v.br = br; v.hilo = hilo; v.exp = exp;
        return v;
    endfunction

    task automatic clear_inputs();
        hif.rs_d = '0; hif.rt_d = '0; hif.rs_e = '0; hif.rt_e = '0;
        hif.write_reg_e = '0; hif.write_reg_m = '0; hif.write_reg_w = '0;
        hif.reg_write_e = 1'b0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
        hif.mem_to_reg_e = 1'b0; hif.mem_to_reg_m = 1'b0;
        hif.branch_d = 1'b0; hif.hilo_read_d = 1'b0;
        hif.md_start_e = 1'b0; hif.md_is_div_e = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hif.rs_d = v.rs_d; hif.rt_d = v.rt_d; hif.rs_e = v.rs_e; hif.rt_e = v.rt_e;
        hif.write_reg_e = v.wre; hif.write_reg_m = v.wrm; hif.write_reg_w = v.wrw;
        hif.reg_write_e = v.rwe; hif.reg_write_m = v.rwm; hif.reg_write_w = v.rww;
        hif.mem_to_reg_e = v.mte; hif.mem_to_reg_m = v.mtm;
        hif.branch_d = v.br; hif.hilo_read_d = v.hilo;
        hif.md_start_e = 1'b0; hif.md_is_div_e = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive md_busy cycles; stops at the first non-busy cycle (negedge sample).
    task automatic run_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!hif.md_busy) break;
            n++;
            check("md_stall", {31'd0, hif.stall_f}, {31'd0, hif.hilo_read_d});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic is_div);
        hif.md_start_e  = 1'b1;
        hif.md_is_div_e = is_div;
        tick();
        hif.md_start_e  = 1'b0;
        hif.md_is_div_e = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] sc0;

        vecs[0]  = mk(8, 0, 0, 0, 8, 0, 0,  1, 0, 0, 1, 0, 0, 0, 10'b1110000000);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 10'b0000000000);
        vecs[2]  = mk(0, 0, 5, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0, 0, 10'b0000010000);
        vecs[3]  = mk(0, 0, 5, 0, 0, 5, 5,  0, 0, 1, 0, 0, 0, 0, 10'b0000001000);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 10'b0000000000);
        vecs[5]  = mk(3, 0, 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 1, 0, 10'b1110000000);
        vecs[6]  = mk(3, 0, 0, 0, 0, 3, 0,  0, 1, 0, 0, 0, 1, 0, 10'b0001000000);
        vecs[7]  = mk(0, 3, 0, 0, 0, 3, 0,  0, 1, 0, 0, 1, 1, 0, 10'b1110100000);
        vecs[8]  = mk(0, 0, 7, 7, 0, 7, 7,  0, 1, 1, 0, 0, 0, 0, 10'b0000010100);
        vecs[9]  = mk(4, 0, 0, 0, 4, 0, 0,  1, 0, 0, 0, 0, 0, 0, 10'b0000000000);
        vecs[10] = mk(1, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 10'b0000000000);
        vecs[11] = mk(0, 9, 0, 0, 9, 0, 0,  0, 0, 0, 1, 0, 0, 0, 10'b1110000000);

        // Reset state, including combinational stalls while reset is held
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("reset_outs", {22'd0, outs()}, 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("reset_count", stall_count, 32'd0);
`endif
        apply(vecs[0]);
        #1;
        check("reset_lw_stall", {22'd0, outs()}, {22'd0, vecs[0].exp});
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), {22'd0, outs()}, {22'd0, vecs[i].exp});
        end
        clear_inputs();
        tick();

        // Load-use stall lasts one cycle, then the load in M just forwards to D
        apply(vecs[0]);
        @(negedge clk);
        check("lw_stall_c0", {22'd0, outs()}, 32'b1110000000);
        tick();
        hif.mem_to_reg_e = 1'b0; hif.write_reg_e = '0; hif.reg_write_e = 1'b0;
        hif.mem_to_reg_m = 1'b1; hif.write_reg_m = 5'd8; hif.reg_write_m = 1'b1;
        @(negedge clk);
        check("lw_stall_c1", {22'd0, outs()}, 32'b0001000000);
        clear_inputs();
        tick();

        // Divide with mfhi waiting in D
`ifdef HAZARD_STALL_COUNT_EN
        sc0 = stall_count;
`else
        sc0 = 32'd0;
`endif
        issue(1'b1);
        hif.hilo_read_d = 1'b1;
        run_busy(n);
        check("div_busy_cycles", n, 32'd11);
        check("div_release", {31'd0, hif.stall_f}, 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("div_stall_count", stall_count - sc0, 32'd11);
`endif
        clear_inputs();
        tick();

        // Asynchronous reset in the middle of a divide
        issue(1'b1);
        tick();
        tick();
        @(negedge clk);
        check("busy_before_rst", {31'd0, hif.md_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, hif.md_busy}, 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        check("async_rst_count", stall_count, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", {31'd0, hif.md_busy}, 32'd0);
        issue(1'b0);
        run_busy(n);
        check("mult_busy_cycles", n, 32'd3);

        // Issue from DONE restarts immediately
        hif.md_start_e = 1'b1;
        tick();
        hif.md_start_e = 1'b0;
        run_busy(n);
        check("b2b_busy_cycles", n, 32'd3);
        clear_inputs();
        tick();

        // Randomized traffic versus a busy-cycles-remaining model
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        busy_left = 0;
        cnt_model = 32'd0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            hif.rs_d = 5'($urandom_range(0, 3));
            hif.rt_d = 5'($urandom_range(0, 3));
            hif.rs_e = 5'($urandom_range(0, 3));
            hif.rt_e = 5'($urandom_range(0, 3));
            hif.write_reg_e = 5'($urandom_range(0, 3));
            hif.write_reg_m = 5'($urandom_range(0, 3));
            hif.write_reg_w = 5'($urandom_range(0, 3));
            hif.reg_write_e = 1'($urandom_range(0, 1));
            hif.reg_write_m = 1'($urandom_range(0, 1));
            hif.reg_write_w = 1'($urandom_range(0, 1));
            hif.mem_to_reg_e = ($urandom_range(0, 3) == 0);
            hif.mem_to_reg_m = ($urandom_range(0, 3) == 0);
            hif.branch_d = ($urandom_range(0, 3) == 0);
            hif.hilo_read_d = 1'($urandom_range(0, 1));
            hif.md_start_e = ($urandom_range(0, 5) == 0);
            hif.md_is_div_e = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rand_outs", {22'd0, outs()}, {22'd0, ref_outs(busy_left > 0)});
`ifdef HAZARD_STALL_COUNT_EN
            check("rand_count", stall_count, cnt_model);
`endif
            if (ref_outs(busy_left > 0) >> 9 != 0) cnt_model = cnt_model + 32'd1;
            if (busy_left > 0) busy_left = busy_left - 1;
            else if (hif.md_start_e) busy_left = hif.md_is_div_e ? 11 : 3;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
